led_fader: RTL and testbench

//  Downstream stage of the LED pattern rotator. Takes the rotator's 6-bit on/off pattern and

---
 rtl/led_fader.sv | 214 +++++++++++++++++++++
 tb/tb_led_fader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// ----------------------------------------------------------------------------
// led_fader
// Turns a per-LED on/off pattern into PWM drive for the LED pads. Each LED
// ramps its brightness linearly between dark and fully lit instead of
// switching hard, so pattern changes fade in and out.
//
// Timebases:
//   pre_cnt  : divides sys_clk by PWM_DIV, one pwm_tick per wrap
//   pwm_cnt  : PWM_BITS sawtooth advanced by pwm_tick, compared with level
//   fade_cnt : divides sys_clk by FADE_DIV, one fade_tick per brightness step
// All three run freely from reset and are never restarted by pattern changes.
//
// Per LED there is a small OFF/RISE/ON/FALL state machine plus a brightness
// level. The level only moves on fade_tick. A direction change always wins
// over a level step in the same cycle, so a reversal mid-ramp continues from
// the current brightness without a jump.
// ----------------------------------------------------------------------------
module led_fader #(
    parameter int NUM_LED    = 6,
    parameter int PWM_BITS   = 8,
    parameter int PWM_DIV    = 4,
    parameter int FADE_DIV   = 26470,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NUM_LED-1:0] pattern,
    output logic [NUM_LED-1:0] led_out,
    output logic               busy
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    // A divide-by-one counter still needs a 1-bit register to stay legal.
    localparam int PRE_W  = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [FADE_W-1:0]   FADE_LAST = FADE_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO  = '0;
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] LVL_NEAR  = LVL_MAX - LVL_ONE;

    // Pad level that leaves every LED dark.
    localparam logic [NUM_LED-1:0]  LED_DARK  = ACTIVE_LOW ? {NUM_LED{1'b1}}
                                                           : {NUM_LED{1'b0}};

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } led_state_t;

    // ------------------------------------------------------------------
    // Timebase registers
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]    pre_cnt_q,  pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [FADE_W-1:0]   fade_cnt_q, fade_cnt_d;
    logic                pwm_tick;
    logic                fade_tick;

    assign pwm_tick  = (pre_cnt_q  == PRE_LAST);
    assign fade_tick = (fade_cnt_q == FADE_LAST);

    // Next-state of the free-running prescaler, PWM sawtooth and fade divider.
    always_comb begin
        pre_cnt_d  = pre_cnt_q;
        pwm_cnt_d  = pwm_cnt_q;
        fade_cnt_d = fade_cnt_q;

        if (pwm_tick) begin
            pre_cnt_d = '0;
            // The sawtooth wraps MAX -> 0 by natural overflow.
            pwm_cnt_d = pwm_cnt_q + LVL_ONE;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        if (fade_tick) begin
            fade_cnt_d = '0;
        end else begin
            fade_cnt_d = fade_cnt_q + FADE_W'(1);
        end
    end

    // Timebase register stage; reset realigns every divider to zero.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-LED fade state machines
    // ------------------------------------------------------------------
    logic [NUM_LED-1:0] lit;      // combinational PWM compare result
    logic [NUM_LED-1:0] moving;   // LED currently ramping

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LED; gi++) begin : g_led
            led_state_t          state_q, state_d;
            logic [PWM_BITS-1:0] level_q, level_d;

            // State and brightness register for this LED.
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    state_q <= ST_OFF;
                    level_q <= '0;
                end else begin
                    state_q <= state_d;
                    level_q <= level_d;
                end
            end

            // Next state / next level. A pattern reversal takes priority
            // over a fade step, so the level holds on the reversal cycle.
            always_comb begin
                state_d = state_q;
                level_d = level_q;

                unique case (state_q)
                    ST_OFF: begin
                        if (pattern[gi]) begin
                            state_d = ST_RISE;
                        end
                    end

                    ST_RISE: begin
                        if (!pattern[gi]) begin
                            state_d = ST_FALL;
                        end else if (fade_tick) begin
                            // A reversal from FALL may leave RISE sitting at
                            // MAX already; the step then saturates there.
                            if ((level_q == LVL_NEAR) || (level_q == LVL_MAX)) begin
                                level_d = LVL_MAX;
                                state_d = ST_ON;
                            end else begin
                                level_d = level_q + LVL_ONE;
                            end
                        end
                    end

                    ST_ON: begin
                        if (!pattern[gi]) begin
                            state_d = ST_FALL;
                        end
                    end

                    ST_FALL: begin
                        if (pattern[gi]) begin
                            state_d = ST_RISE;
                        end else if (fade_tick) begin
                            // Mirror of RISE: a short OFF->RISE->FALL blip can
                            // leave FALL at level 0, which must not underflow.
                            if ((level_q == LVL_ONE) || (level_q == LVL_ZERO)) begin
                                level_d = LVL_ZERO;
                                state_d = ST_OFF;
                            end else begin
                                level_d = level_q - LVL_ONE;
                            end
                        end
                    end

                    default: begin
                        state_d = ST_OFF;
                        level_d = '0;
                    end
                endcase
            end

            // MAX is forced fully on; otherwise duty is level / 2**PWM_BITS.
            assign lit[gi]    = (level_q == LVL_MAX) | (pwm_cnt_q < level_q);
            assign moving[gi] = (state_q == ST_RISE) | (state_q == ST_FALL);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [NUM_LED-1:0] led_out_q, led_out_d;
    logic               busy_q,    busy_d;

    // Pad polarity and activity summary feeding the output registers.
    always_comb begin
        led_out_d = ACTIVE_LOW ? ~lit : lit;
        busy_d    = |moving;
    end

    // Registered pad drive and busy flag; both show dark/idle after reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            led_out_q <= LED_DARK;
            busy_q    <= 1'b0;
        end else begin
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
        end
    end

    assign led_out = led_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// ----------------------------------------------------------------------------
// tb_led_fader
// Two instances share one pattern bus: instance 0 uses the reference
// simulation settings (PWM_BITS=4, PWM_DIV=1, FADE_DIV=2, active-low pads),
// instance 1 uses PWM_DIV=3, FADE_DIV=5 and active-high pads so the
// prescaler and polarity paths are exercised too. A cycle-count based
// model predicts led_out/busy for both and is compared on every cycle.
// ----------------------------------------------------------------------------
module tb_led_fader;

    localparam int NL   = 6;
    localparam int MAXL = 15;

    localparam int M_OFF  = 0;
    localparam int M_RISE = 1;
    localparam int M_ON   = 2;
    localparam int M_FALL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NL-1:0] pattern = '0;
    logic [NL-1:0] led0, led1;
    logic          busy0, busy1;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    led_fader #(
        .NUM_LED(NL), .PWM_BITS(4), .PWM_DIV(1), .FADE_DIV(2), .ACTIVE_LOW(1'b1)
    ) u_dut0 (
        .sys_clk(clk), .sys_rst(rst), .pattern(pattern), .led_out(led0), .busy(busy0)
    );

    led_fader #(
        .NUM_LED(NL), .PWM_BITS(4), .PWM_DIV(3), .FADE_DIV(5), .ACTIVE_LOW(1'b0)
    ) u_dut1 (
        .sys_clk(clk), .sys_rst(rst), .pattern(pattern), .led_out(led1), .busy(busy1)
    );

    function automatic int pd(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int fd(input int k);
        return (k == 0) ? 2 : 5;
    endfunction

    function automatic bit act_low(input int k);
        return (k == 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: timebases derived from cycles since reset (n);
    // each LED keeps a brightness and a ramp direction.
    // ------------------------------------------------------------------
    int          n;
    int          mlvl [2][NL];
    int          mst  [2][NL];
    logic [NL-1:0] m_led [2];
    logic        m_busy [2];

    int          pwmv;
    bit          tick;
    bit          bz;
    bit          lt;
    logic [NL-1:0] img;

    always @(posedge clk) begin
        if (rst) begin
            n = 0;
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NL; i++) begin
                    mlvl[k][i] = 0;
                    mst[k][i]  = M_OFF;
                end
                m_busy[k] = 1'b0;
            end
            m_led[0] = '1;
            m_led[1] = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                pwmv = (n / pd(k)) % (MAXL + 1);
                tick = ((n % fd(k)) == fd(k) - 1);
                bz   = 1'b0;
                for (int i = 0; i < NL; i++) begin
                    lt     = (mlvl[k][i] == MAXL) || (pwmv < mlvl[k][i]);
                    img[i] = act_low(k) ? !lt : lt;
                    if (mst[k][i] == M_RISE || mst[k][i] == M_FALL) bz = 1'b1;
                end
                m_led[k]  = img;
                m_busy[k] = bz;
                for (int i = 0; i < NL; i++) begin
                    case (mst[k][i])
                        M_OFF:  if (pattern[i]) mst[k][i] = M_RISE;
                        M_ON:   if (!pattern[i]) mst[k][i] = M_FALL;
                        M_RISE: begin
                            if (!pattern[i]) mst[k][i] = M_FALL;
                            else if (tick) begin
                                mlvl[k][i] = (mlvl[k][i] + 1 > MAXL) ? MAXL : mlvl[k][i] + 1;
                                if (mlvl[k][i] == MAXL) mst[k][i] = M_ON;
                            end
                        end
                        default: begin
                            if (pattern[i]) mst[k][i] = M_RISE;
                            else if (tick) begin
                                mlvl[k][i] = (mlvl[k][i] - 1 < 0) ? 0 : mlvl[k][i] - 1;
                                if (mlvl[k][i] == 0) mst[k][i] = M_OFF;
                            end
                        end
                    endcase
                end
            end
            n++;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_led0",  int'(led0),  int'(m_led[0]));
            chk("cyc_busy0", int'(busy0), int'(m_busy[0]));
            chk("cyc_led1",  int'(led1),  int'(m_led[1]));
            chk("cyc_busy1", int'(busy1), int'(m_busy[1]));
        end
    end

    // ------------------------------------------------------------------
    // Directed phases followed by random traffic
    // ------------------------------------------------------------------
    int  maxl;
    bit  found;

    initial begin
        rst = 1'b1;
        pattern = '0;
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_led0",  int'(led0),  'h3f);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_led1",  int'(led1),  'h00);
        $display("txn reset: led0=%b led1=%b busy0=%b", led0, led1, busy0);

        rst = 1'b0;
        repeat (1000) @(negedge clk);
        chk("idle_led0",  int'(led0),  'h3f);
        chk("idle_busy0", int'(busy0), 0);
        $display("txn idle 1000 cycles: led0=%b", led0);

        // Single LED ramp up
        pattern = 6'b000001;
        @(negedge clk);
        chk("busy_lag0", int'(busy0), 0);
        @(negedge clk);
        chk("busy_set0", int'(busy0), 1);
        repeat (38) @(negedge clk);
        chk("ramp_lvl_model", mlvl[0][0], 15);
        chk("ramp_led0",  int'(led0),  'h3e);
        chk("ramp_busy0", int'(busy0), 0);
        $display("txn ramp up: led0=%b busy0=%b", led0, busy0);
        repeat (80) @(negedge clk);

        // Reversal aligned with fade_tick at level 5
        pattern = '0;
        repeat (120) @(negedge clk);
        pattern = 6'b000001;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (mlvl[0][0] == 5 && (n % 2) == 1) found = 1'b1;
        end
        chk("wait_lvl5", int'(found), 1);
        pattern = '0;
        @(negedge clk);
        chk("rev_hold_model", mlvl[0][0], 5);
        chk("rev_state_model", mst[0][0], M_FALL);
        maxl = mlvl[0][0];
        repeat (30) begin
            @(negedge clk);
            if (mlvl[0][0] > maxl) maxl = mlvl[0][0];
        end
        chk("rev_max_model", maxl, 5);
        chk("rev_end_model", mlvl[0][0], 0);
        chk("rev_led0_dark", int'(led0[0]), 1);
        $display("txn reversal at 5: max=%0d led0=%b", maxl, led0);
        repeat (60) @(negedge clk);

        // Reset mid-ramp at level 7
        pattern = 6'b000001;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (mlvl[0][0] == 7) found = 1'b1;
        end
        chk("wait_lvl7", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_led0",  int'(led0),  'h3f);
        chk("midrst_busy0", int'(busy0), 0);
        chk("midrst_led1",  int'(led1),  'h00);
        chk("midrst_lvl_model", mlvl[0][0], 0);
        repeat (5) @(negedge clk);
        chk("restart_lvl_model", mlvl[0][0], 2);
        $display("txn reset mid-ramp: led0=%b", led0);

        // Independent multi-bit changes
        pattern = '0;
        repeat (150) @(negedge clk);
        pattern = 6'b101110;
        repeat (150) @(negedge clk);
        pattern = 6'b011101;
        repeat (150) @(negedge clk);
        chk("multi_led0",  int'(led0),  'h22);
        chk("multi_busy0", int'(busy0), 0);
        chk("multi_led1",  int'(led1),  'h1d);
        chk("multi_busy1", int'(busy1), 0);
        $display("txn multi-bit: led0=%b led1=%b", led0, led1);

        // Random pattern traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) pattern = NL'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        $display("txn random 3000 cycles done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
